uart_xcvr: RTL and testbench
============================

Name: uart_xcvr

Overview:
- Parametrised UART transceiver: one transmitter and one receiver share a clock and a bit-period setting.
- Generalises the existing fixed 8-bit, even-parity, single-stop trans/rece pair:
  - configurable data width, parity mode and stop-bit count;
  - valid/ready transmit handshake;
  - mid-bit sampled receiver with input synchroniser, false-start rejection, and parity and framing error flags.
- Sits between a byte-stream client and the serial pins; tx can be looped back to rx for self-test.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit (>=4).
- DATA_BITS, 8, payload bits per frame (5..9).
- PARITY, 2, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame (1 or 2).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous active-high reset.
- tx_data  in  DATA_BITS  payload to send.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  transmitter can accept a word.
- tx  out  1  serial output, idle high.
- tx_busy  out  1  a frame is in progress.
- rx  in  1  serial input, asynchronous.
- rx_data  out  DATA_BITS  last received payload.
- rx_valid  out  1  one-cycle pulse: rx_data and the error flags are updated.
- rx_parity_err  out  1  parity mismatch on last frame (0 when PARITY = 0).
- rx_frame_err  out  1  a stop bit sampled 0 on last frame.

Behaviour:
- Reset (asynchronous, immediate):
  - tx = 1, tx_ready = 1 (after release), tx_busy = 0;
  - rx_data = 0, rx_valid = 0, both error flags = 0;
  - both FSMs IDLE, bit counters 0, rx synchroniser flops = 1.
  - Reset mid-frame aborts the frame with no partial output.
- TX FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: tx = 1, tx_ready = 1. On tx_valid & tx_ready, latch tx_data, go to START next cycle; tx_ready = 0 from that cycle.
  - Each bit is driven for exactly CLKS_PER_BIT cycles, counted by a baud counter.
  - Bit order: start (0), data LSB first, parity (omitted when PARITY = 0), STOP_BITS stop bits (1).
  - Even parity: the parity bit makes the total count of ones in data plus parity even. Odd parity: makes it odd.
  - After the last stop-bit cycle, return to IDLE with tx_ready = 1 in the next cycle.
  - Back-to-back: a word accepted in the first IDLE cycle produces its start bit in the following cycle, so the line holds one extra idle cycle at most.
  - tx_valid with tx_ready = 0 is ignored; tx_data is not sampled.
  - tx_busy = ~tx_ready.
- RX path: rx passes through a 2-flop synchroniser; all decisions use the synchronised value rs.
- RX FSM states: IDLE, START, DATA, PAR, STOP, WAITHI.
  - IDLE: on rs = 0, go to START and clear the baud counter.
  - START: after CLKS_PER_BIT/2 cycles, resample. If rs = 1, it is a glitch: return to IDLE with no output. Otherwise go to DATA.
  - DATA and PAR: sample each bit every CLKS_PER_BIT cycles (mid-bit). Shift in LSB first.
  - STOP: sample each stop bit mid-bit. Any 0 sets the frame error.
  - At the last stop sample, update rx_data, rx_parity_err and rx_frame_err, and pulse rx_valid for 1 cycle.
  - Then go to IDLE if rs = 1; go to WAITHI if it is a framing error (line low / break).
  - WAITHI: stay until rs = 1, then IDLE. No new frame starts while the line is held low.
- Data and errors are always delivered together; a parity error does not suppress rx_data.
- Flags hold their value until the next rx_valid.
- RX latency: rx_valid occurs 2 + CLKS_PER_BIT/2 + (frame_bits−1)·CLKS_PER_BIT cycles (±1) after the falling rx edge, where frame_bits = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS.
- TX and RX are fully independent and may run simultaneously.

Test Plan:
1. Defaults, tx looped to rx, send 0xA5:
   - tx: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1, each bit held 16 cycles, 176 cycles total;
   - rx_valid once, rx_data = 0xA5, both error flags 0.
   - With PARITY = 1: parity bit = 1.
2. Back-to-back 0x00 then 0xFF with tx_valid held high:
   - tx_ready low for 176 cycles per word;
   - second start bit within 1 cycle of the first frame's stop end;
   - rx receives 0x00 then 0xFF in order.
3. Bench drives rx with 0x3C and a flipped parity bit:
   - rx_parity_err = 1, rx_data = 0x3C, rx_frame_err = 0.
   - The next clean frame clears the flag.
4. Bench drives a frame with stop bit 0, then holds rx low for 100 cycles:
   - rx_frame_err = 1, rx_valid exactly once;
   - no further rx_valid until rx returns high and a new valid frame arrives.
5. rx pulsed low for 4 cycles (less than CLKS_PER_BIT/2):
   - no rx_valid; the next valid frame (0x5A) is received correctly.
6. rst asserted during TX data bit 3 and during RX data bit 3:
   - tx = 1 immediately, without waiting for clk;
   - after release, tx_ready = 1, rx_valid never pulses for the aborted frame;
   - a subsequent 0x81 transfers correctly.
   - Also run case 1 with STOP_BITS = 2 and DATA_BITS = 7: 0x55 is received and the frame is 11·16 cycles long.

Source files
------------

// File: rtl/uart_xcvr_if.sv
// Byte-stream and serial-pin bundle of the UART transceiver.
// The client/bench side drives tx_data, tx_valid and rx; the transceiver drives the rest.
interface uart_xcvr_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx;
    logic                 tx_busy;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_parity_err;
    logic                 rx_frame_err;

    modport master (
        output tx_data, tx_valid, rx,
        input  tx_ready, tx, tx_busy, rx_data, rx_valid, rx_parity_err, rx_frame_err
    );

    modport slave (
        input  tx_data, tx_valid, rx,
        output tx_ready, tx, tx_busy, rx_data, rx_valid, rx_parity_err, rx_frame_err
    );
endinterface

// File: rtl/uart_xcvr.sv
// Parametrised UART transceiver: an independent transmitter and mid-bit sampling receiver
// sharing one bit period, with configurable width, parity and stop-bit count.
module uart_xcvr #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 2,
    parameter int STOP_BITS    = 1
) (
    input  logic        clk,
    input  logic        rst,
    uart_xcvr_if.slave  bus
);
    localparam int              BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]   BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic            HAS_PAR   = (PARITY != 0);
    localparam logic            ODD_PAR   = (PARITY == 1);

    // ---------------- transmitter ----------------
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_e;

    tx_state_e            tx_state_q, tx_state_d;
    logic [BW-1:0]        tx_baud_q, tx_baud_d;
    logic [3:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_line;
    logic                 tx_rdy;
    logic                 tx_bit_end;

    assign tx_bit_end = (tx_baud_q == BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
        end
    end

    // The line level is decoded from state so reset forces it high without a clock.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_baud_d  = tx_baud_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_line    = 1'b1;
        tx_rdy     = 1'b0;
        if (tx_state_q != TX_IDLE)
            tx_baud_d = tx_bit_end ? '0 : tx_baud_q + 1'b1;
        unique case (tx_state_q)
            TX_IDLE: begin
                tx_rdy = 1'b1;
                if (bus.tx_valid) begin
                    tx_shift_d = bus.tx_data;
                    tx_par_d   = (^bus.tx_data) ^ ODD_PAR;
                    tx_baud_d  = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                tx_line = 1'b0;
                if (tx_bit_end) tx_state_d = TX_DATA;
            end
            TX_DATA: begin
                tx_line = tx_shift_q[0];
                if (tx_bit_end) begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == DATA_LAST) begin
                        tx_bit_d   = '0;
                        tx_state_d = HAS_PAR ? TX_PAR : TX_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                end
            end
            TX_PAR: begin
                tx_line = tx_par_q;
                if (tx_bit_end) tx_state_d = TX_STOP;
            end
            TX_STOP: begin
                tx_line = 1'b1;
                if (tx_bit_end) begin
                    if (tx_bit_q == STOP_LAST) begin
                        tx_bit_d   = '0;
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign bus.tx       = tx_line;
    assign bus.tx_ready = tx_rdy;
    assign bus.tx_busy  = ~tx_rdy;

    // ---------------- receiver ----------------
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAITHI} rx_state_e;

    logic                 sync_q, rs_q;
    rx_state_e            rx_state_q, rx_state_d;
    logic [BW-1:0]        rx_baud_q, rx_baud_d;
    logic [3:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_acc_q, rx_acc_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_perr_out_q, rx_perr_out_d;
    logic                 rx_ferr_out_q, rx_ferr_out_d;
    logic                 rx_sample;

    assign rx_sample = (rx_baud_q == BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q        <= 1'b1;
            rs_q          <= 1'b1;
            rx_state_q    <= RX_IDLE;
            rx_baud_q     <= '0;
            rx_bit_q      <= '0;
            rx_shift_q    <= '0;
            rx_acc_q      <= 1'b0;
            rx_ferr_q     <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_perr_out_q <= 1'b0;
            rx_ferr_out_q <= 1'b0;
        end else begin
            sync_q        <= bus.rx;
            rs_q          <= sync_q;
            rx_state_q    <= rx_state_d;
            rx_baud_q     <= rx_baud_d;
            rx_bit_q      <= rx_bit_d;
            rx_shift_q    <= rx_shift_d;
            rx_acc_q      <= rx_acc_d;
            rx_ferr_q     <= rx_ferr_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_perr_out_q <= rx_perr_out_d;
            rx_ferr_out_q <= rx_ferr_out_d;
        end
    end

    // rx_acc_q is the running XOR of data and parity bits; it must equal ODD_PAR on a good frame.
    always_comb begin
        rx_state_d    = rx_state_q;
        rx_baud_d     = rx_baud_q;
        rx_bit_d      = rx_bit_q;
        rx_shift_d    = rx_shift_q;
        rx_acc_d      = rx_acc_q;
        rx_ferr_d     = rx_ferr_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        rx_perr_out_d = rx_perr_out_q;
        rx_ferr_out_d = rx_ferr_out_q;
        if (rx_state_q inside {RX_DATA, RX_PAR, RX_STOP})
            rx_baud_d = rx_sample ? '0 : rx_baud_q + 1'b1;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (!rs_q) begin
                    rx_baud_d  = '0;
                    rx_bit_d   = '0;
                    rx_acc_d   = 1'b0;
                    rx_ferr_d  = 1'b0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_baud_q == BAUD_HALF) begin
                    rx_baud_d  = '0;
                    rx_state_d = rs_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_baud_d = rx_baud_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_sample) begin
                    rx_shift_d = {rs_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_acc_d   = rx_acc_q ^ rs_q;
                    if (rx_bit_q == DATA_LAST) begin
                        rx_bit_d   = '0;
                        rx_state_d = HAS_PAR ? RX_PAR : RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 4'd1;
                    end
                end
            end
            RX_PAR: begin
                if (rx_sample) begin
                    rx_acc_d   = rx_acc_q ^ rs_q;
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_sample) begin
                    if (rx_bit_q == STOP_LAST) begin
                        rx_bit_d      = '0;
                        rx_data_d     = rx_shift_q;
                        rx_perr_out_d = HAS_PAR & (rx_acc_q != ODD_PAR);
                        rx_ferr_out_d = rx_ferr_q | ~rs_q;
                        rx_valid_d    = 1'b1;
                        rx_state_d    = rs_q ? RX_IDLE : RX_WAITHI;
                    end else begin
                        rx_ferr_d = rx_ferr_q | ~rs_q;
                        rx_bit_d  = rx_bit_q + 4'd1;
                    end
                end
            end
            RX_WAITHI: begin
                if (rs_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign bus.rx_data       = rx_data_q;
    assign bus.rx_valid      = rx_valid_q;
    assign bus.rx_parity_err = rx_perr_out_q;
    assign bus.rx_frame_err  = rx_ferr_out_q;
endmodule

// File: tb/tb_uart_xcvr.sv
// Directed bench for uart_xcvr: default, odd-parity and 7-bit/2-stop instances,
// loopback and bench-driven serial frames, error flags, glitches and mid-frame reset.
module tb_uart_xcvr;
    logic clk;
    logic rst;
    logic loop0;
    logic rx_drv;
    int   cmp;
    int   errs;

    uart_xcvr_if #(.DATA_BITS(8)) if0();
    uart_xcvr_if #(.DATA_BITS(8)) if1();
    uart_xcvr_if #(.DATA_BITS(7)) if2();

    uart_xcvr #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
        dut0 (.clk(clk), .rst(rst), .bus(if0));
    uart_xcvr #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
        dut1 (.clk(clk), .rst(rst), .bus(if1));
    uart_xcvr #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2))
        dut2 (.clk(clk), .rst(rst), .bus(if2));

    assign if0.rx = loop0 ? if0.tx : rx_drv;
    assign if1.rx = if1.tx;
    assign if2.rx = if2.tx;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         vcnt0, vcnt1, vcnt2;
    logic [7:0] last0, last1;
    logic [6:0] last2;
    logic       pe0, fe0, pe1, fe1, pe2, fe2;
    logic [7:0] q0[$];

    always @(negedge clk) begin
        if (if0.rx_valid === 1'b1) begin
            vcnt0 <= vcnt0 + 1;
            last0 <= if0.rx_data;
            pe0   <= if0.rx_parity_err;
            fe0   <= if0.rx_frame_err;
            q0.push_back(if0.rx_data);
        end
        if (if1.rx_valid === 1'b1) begin
            vcnt1 <= vcnt1 + 1;
            last1 <= if1.rx_data;
            pe1   <= if1.rx_parity_err;
            fe1   <= if1.rx_frame_err;
        end
        if (if2.rx_valid === 1'b1) begin
            vcnt2 <= vcnt2 + 1;
            last2 <= if2.rx_data;
            pe2   <= if2.rx_parity_err;
            fe2   <= if2.rx_frame_err;
        end
    end

    // Bench-driven serial frame into dut0, bit 0 first, 16 cycles per bit.
    task automatic drive_rx(input logic [10:0] f, input int nb, input logic endlvl);
        for (int i = 0; i < nb; i++) begin
            rx_drv = f[i];
            repeat (16) @(negedge clk);
        end
        rx_drv = endlvl;
    endtask

    task automatic send0(input logic [7:0] d);
        int n;
        @(negedge clk);
        if0.tx_data  = d;
        if0.tx_valid = 1'b1;
        @(negedge clk);
        if0.tx_valid = 1'b0;
        n = 0;
        while (if0.tx_ready !== 1'b1 && n < 400) begin
            n++;
            @(negedge clk);
        end
        cmp++;
        if (n >= 400) begin
            errs++;
            $display("FAIL send0_timeout: tx_ready stuck low after %0d cycles, want high within 400", n);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        cmp++; if (if0.tx !== 1'b1) begin errs++; $display("FAIL reset_tx: got %b want 1", if0.tx); end
        cmp++; if (if0.tx_busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", if0.tx_busy); end
        cmp++; if (if0.rx_data !== 8'h00) begin errs++; $display("FAIL reset_rxdata: got %h want 00", if0.rx_data); end
        cmp++; if (if0.rx_valid !== 1'b0) begin errs++; $display("FAIL reset_rxvalid: got %b want 0", if0.rx_valid); end
        cmp++; if (if0.rx_parity_err !== 1'b0 || if0.rx_frame_err !== 1'b0) begin
            errs++; $display("FAIL reset_flags: got pe=%b fe=%b want 0 0", if0.rx_parity_err, if0.rx_frame_err);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        cmp++; if (if0.tx_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", if0.tx_ready); end
    endtask

    task automatic test_loopback();
        logic [10:0] exp;
        int n, v;
        exp = {1'b1, 1'b0, 8'hA5, 1'b0};
        loop0 = 1'b1;
        v = vcnt0;
        @(negedge clk);
        if0.tx_data  = 8'hA5;
        if0.tx_valid = 1'b1;
        @(negedge clk);
        if0.tx_valid = 1'b0;
        n = 0;
        while (if0.tx_ready === 1'b0 && n < 400) begin
            if (n % 16 == 8 && n / 16 < 11) begin
                cmp++;
                if (if0.tx !== exp[n/16]) begin
                    errs++; $display("FAIL loop_txbit%0d: got %b want %b", n / 16, if0.tx, exp[n/16]);
                end
            end
            n++;
            @(negedge clk);
        end
        cmp++; if (n != 176) begin errs++; $display("FAIL loop_frame_len: got %0d want 176", n); end
        repeat (20) @(negedge clk);
        cmp++; if (vcnt0 - v != 1) begin errs++; $display("FAIL loop_rxcount: got %0d want 1", vcnt0 - v); end
        cmp++; if (last0 !== 8'hA5) begin errs++; $display("FAIL loop_rxdata: got %h want a5", last0); end
        cmp++; if (pe0 !== 1'b0 || fe0 !== 1'b0) begin
            errs++; $display("FAIL loop_flags: got pe=%b fe=%b want 0 0", pe0, fe0);
        end
    endtask

    task automatic test_odd_parity();
        int n, v;
        v = vcnt1;
        @(negedge clk);
        if1.tx_data  = 8'hA5;
        if1.tx_valid = 1'b1;
        @(negedge clk);
        if1.tx_valid = 1'b0;
        n = 0;
        while (if1.tx_ready === 1'b0 && n < 400) begin
            if (n == 9 * 16 + 8) begin
                cmp++;
                if (if1.tx !== 1'b1) begin errs++; $display("FAIL odd_parbit: got %b want 1", if1.tx); end
            end
            n++;
            @(negedge clk);
        end
        repeat (20) @(negedge clk);
        cmp++; if (vcnt1 - v != 1 || last1 !== 8'hA5 || pe1 !== 1'b0 || fe1 !== 1'b0) begin
            errs++; $display("FAIL odd_rx: got cnt=%0d data=%h pe=%b fe=%b want 1 a5 0 0", vcnt1 - v, last1, pe1, fe1);
        end
    endtask

    task automatic test_back_to_back();
        int n1, gap, n2, v;
        loop0 = 1'b1;
        v = vcnt0;
        q0.delete();
        @(negedge clk);
        if0.tx_data  = 8'h00;
        if0.tx_valid = 1'b1;
        @(negedge clk);
        if0.tx_data = 8'hFF;
        n1 = 0;
        while (if0.tx_ready === 1'b0 && n1 < 400) begin n1++; @(negedge clk); end
        gap = 0;
        while (if0.tx_ready === 1'b1 && gap < 400) begin gap++; @(negedge clk); end
        if0.tx_valid = 1'b0;
        cmp++; if (if0.tx !== 1'b0) begin errs++; $display("FAIL b2b_start2: got %b want 0", if0.tx); end
        n2 = 0;
        while (if0.tx_ready === 1'b0 && n2 < 400) begin n2++; @(negedge clk); end
        cmp++; if (n1 != 176) begin errs++; $display("FAIL b2b_len1: got %0d want 176", n1); end
        cmp++; if (gap > 1) begin errs++; $display("FAIL b2b_gap: got %0d want <=1", gap); end
        cmp++; if (n2 != 176) begin errs++; $display("FAIL b2b_len2: got %0d want 176", n2); end
        repeat (20) @(negedge clk);
        cmp++;
        if (q0.size() != 2 || vcnt0 - v != 2) begin
            errs++; $display("FAIL b2b_rxcount: got %0d want 2", q0.size());
        end else begin
            cmp++;
            if (q0[0] !== 8'h00 || q0[1] !== 8'hFF) begin
                errs++; $display("FAIL b2b_rxorder: got %h %h want 00 ff", q0[0], q0[1]);
            end
        end
    endtask

    task automatic test_parity_err();
        int v;
        @(negedge clk);
        loop0  = 1'b0;
        rx_drv = 1'b1;
        v = vcnt0;
        drive_rx({1'b1, 1'b1, 8'h3C, 1'b0}, 11, 1'b1);
        repeat (20) @(negedge clk);
        cmp++; if (vcnt0 - v != 1) begin errs++; $display("FAIL perr_count: got %0d want 1", vcnt0 - v); end
        cmp++; if (last0 !== 8'h3C) begin errs++; $display("FAIL perr_data: got %h want 3c", last0); end
        cmp++; if (pe0 !== 1'b1 || fe0 !== 1'b0) begin
            errs++; $display("FAIL perr_flags: got pe=%b fe=%b want 1 0", pe0, fe0);
        end
        cmp++; if (if0.rx_parity_err !== 1'b1) begin
            errs++; $display("FAIL perr_hold: got %b want 1", if0.rx_parity_err);
        end
        drive_rx({1'b1, 1'b0, 8'h3C, 1'b0}, 11, 1'b1);
        repeat (20) @(negedge clk);
        cmp++; if (vcnt0 - v != 2 || last0 !== 8'h3C || pe0 !== 1'b0) begin
            errs++; $display("FAIL perr_clear: got cnt=%0d data=%h pe=%b want 2 3c 0", vcnt0 - v, last0, pe0);
        end
    endtask

    task automatic test_frame_err();
        int v;
        v = vcnt0;
        drive_rx({1'b0, 1'b0, 8'h81, 1'b0}, 11, 1'b0);
        repeat (100) @(negedge clk);
        cmp++; if (vcnt0 - v != 1) begin errs++; $display("FAIL ferr_count: got %0d want 1", vcnt0 - v); end
        cmp++; if (fe0 !== 1'b1 || pe0 !== 1'b0 || last0 !== 8'h81) begin
            errs++; $display("FAIL ferr_flags: got fe=%b pe=%b data=%h want 1 0 81", fe0, pe0, last0);
        end
        rx_drv = 1'b1;
        repeat (30) @(negedge clk);
        cmp++; if (vcnt0 - v != 1) begin errs++; $display("FAIL ferr_break: got %0d want 1", vcnt0 - v); end
        drive_rx({1'b1, 1'b0, 8'h5A, 1'b0}, 11, 1'b1);
        repeat (20) @(negedge clk);
        cmp++; if (vcnt0 - v != 2 || last0 !== 8'h5A || fe0 !== 1'b0) begin
            errs++; $display("FAIL ferr_recover: got cnt=%0d data=%h fe=%b want 2 5a 0", vcnt0 - v, last0, fe0);
        end
    endtask

    task automatic test_glitch();
        int v;
        v = vcnt0;
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        cmp++; if (vcnt0 != v) begin errs++; $display("FAIL glitch_novalid: got %0d want 0", vcnt0 - v); end
        drive_rx({1'b1, 1'b0, 8'h5A, 1'b0}, 11, 1'b1);
        repeat (20) @(negedge clk);
        cmp++; if (vcnt0 - v != 1 || last0 !== 8'h5A || pe0 !== 1'b0 || fe0 !== 1'b0) begin
            errs++; $display("FAIL glitch_next: got cnt=%0d data=%h pe=%b fe=%b want 1 5a 0 0", vcnt0 - v, last0, pe0, fe0);
        end
    endtask

    task automatic test_reset_midframe();
        int v;
        @(negedge clk);
        loop0 = 1'b1;
        v = vcnt0;
        if0.tx_data  = 8'h81;
        if0.tx_valid = 1'b1;
        @(negedge clk);
        if0.tx_valid = 1'b0;
        repeat (70) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        cmp++; if (if0.tx !== 1'b1) begin errs++; $display("FAIL rstmid_tx: got %b want 1", if0.tx); end
        cmp++; if (if0.tx_busy !== 1'b0) begin errs++; $display("FAIL rstmid_busy: got %b want 0", if0.tx_busy); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cmp++; if (if0.tx_ready !== 1'b1) begin errs++; $display("FAIL rstmid_ready: got %b want 1", if0.tx_ready); end
        cmp++; if (if0.rx_data !== 8'h00) begin errs++; $display("FAIL rstmid_rxdata: got %h want 00", if0.rx_data); end
        repeat (200) @(negedge clk);
        cmp++; if (vcnt0 != v) begin errs++; $display("FAIL rstmid_novalid: got %0d want 0", vcnt0 - v); end
        send0(8'h81);
        cmp++; if (vcnt0 - v != 1 || last0 !== 8'h81 || pe0 !== 1'b0 || fe0 !== 1'b0) begin
            errs++; $display("FAIL rstmid_after: got cnt=%0d data=%h pe=%b fe=%b want 1 81 0 0", vcnt0 - v, last0, pe0, fe0);
        end
    endtask

    task automatic test_7bit_2stop();
        logic [10:0] exp;
        int n, v;
        exp = {1'b1, 1'b1, 1'b0, 7'h55, 1'b0};
        v = vcnt2;
        @(negedge clk);
        if2.tx_data  = 7'h55;
        if2.tx_valid = 1'b1;
        @(negedge clk);
        if2.tx_valid = 1'b0;
        n = 0;
        while (if2.tx_ready === 1'b0 && n < 400) begin
            if (n % 16 == 8 && n / 16 < 11) begin
                cmp++;
                if (if2.tx !== exp[n/16]) begin
                    errs++; $display("FAIL w7_txbit%0d: got %b want %b", n / 16, if2.tx, exp[n/16]);
                end
            end
            n++;
            @(negedge clk);
        end
        cmp++; if (n != 176) begin errs++; $display("FAIL w7_frame_len: got %0d want 176", n); end
        repeat (20) @(negedge clk);
        cmp++; if (vcnt2 - v != 1 || last2 !== 7'h55 || pe2 !== 1'b0 || fe2 !== 1'b0) begin
            errs++; $display("FAIL w7_rx: got cnt=%0d data=%h pe=%b fe=%b want 1 55 0 0", vcnt2 - v, last2, pe2, fe2);
        end
    endtask

    initial begin
        cmp = 0;
        errs = 0;
        vcnt0 = 0; vcnt1 = 0; vcnt2 = 0;
        loop0 = 1'b1;
        rx_drv = 1'b1;
        if0.tx_data = '0; if0.tx_valid = 1'b0;
        if1.tx_data = '0; if1.tx_valid = 1'b0;
        if2.tx_data = '0; if2.tx_valid = 1'b0;
        test_reset();
        test_loopback();
        test_odd_parity();
        test_back_to_back();
        test_parity_err();
        test_frame_err();
        test_glitch();
        test_reset_midframe();
        test_7bit_2stop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
